dsram_responder: RTL and testbench
==================================

DSRAM_RESPONDER -- requirements
Module: dsram_responder

Interface
REQ-001 Parameter: AW_WORDS, default 12, log2 of array depth in 32-bit words (4096 words).
REQ-002 Parameter: WB_DEPTH, default 4, write-buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 data_sram_en  input  1  request valid this cycle.
REQ-006 data_sram_wen  input  4  byte write enables; 4'b0000 with en=1 means read.
REQ-007 data_sram_addr  input  32  byte address; word index = addr[AW_WORDS+1:2]; addr[1:0] and upper bits ignored.
REQ-008 data_sram_wdata  input  32  write data; byte i = wdata[8i+7:8i].
REQ-009 data_sram_rdata  output  32  read data, registered.
REQ-010 wbuf_count  output  3  number of valid write-buffer entries, 0..WB_DEPTH.
REQ-011 wbuf_empty  output  1  high when wbuf_count==0.

Function
REQ-012 The block shall serve the core's data-SRAM port: read data for a request presented in cycle N shall appear on data_sram_rdata after edge N+1, with fixed 1-cycle latency and no back-pressure.
REQ-013 data_sram_rdata shall hold its value until the next read request completes; write and idle cycles shall not change it.
REQ-014 A write request (en=1, wen!=0) shall be pushed into a FIFO write buffer as {word index, wen mask, wdata}; the array is not written in that cycle except by the forced-drain rule.
REQ-015 The array shall be single-ported: one access per cycle, either a read or a drain.
REQ-016 Drain: when buffer non-empty and en=0, the head entry shall be written to the array with only its enabled bytes, then popped.
REQ-017 Forced drain: when buffer full (count==WB_DEPTH) and a write arrives, the head shall drain and the new entry push in the same cycle; count stays WB_DEPTH; no write is ever dropped.
REQ-018 A read cycle shall never drain; a buffered write shall never be lost because of reads.
REQ-019 Read forwarding: for each byte of a read, the youngest valid buffer entry with a matching word index and that byte enabled shall supply the byte; otherwise the array byte is used.
REQ-020 Forwarding match shall be evaluated against the buffer contents at the start of the read cycle, so reads always return the latest written value in program order.
REQ-021 Writes to the same word shall drain in FIFO order; later partial writes shall overlay earlier bytes in the array.
REQ-022 en=0 with empty buffer shall be a no-op; wen with en=0 shall be ignored.
REQ-023 wbuf_count shall update at the edge: +1 on push only, -1 on drain only, unchanged on push+drain.
REQ-024 Array contents shall not be reset or initialised by logic; unwritten words read as undefined.

Reset
REQ-025 On rst low, asynchronously: data_sram_rdata=32'h0, wbuf_count=0, wbuf_empty=1, FIFO pointers cleared, all entries invalid.
REQ-026 Reset mid-operation shall discard all undrained writes; array words already drained shall be retained.
REQ-027 The first request shall be accepted at the first rising edge after rst deasserts.

Verification
REQ-028 Write word 0x100 = 32'hDEADBEEF wen=4'hF, then read 0x100 next cycle -> rdata=32'hDEADBEEF one cycle later (forwarded, wbuf_count=1).
REQ-029 Write 0x200 = 32'h11223344 (4'hF), write 0x200 = 32'h000000AA (wen=4'h1), read 0x200 -> rdata=32'h112233AA; after two idle cycles wbuf_empty=1 and re-read returns 32'h112233AA from the array.
REQ-030 Five back-to-back full writes to 0x0,0x4,0x8,0xC,0x10 (data 1..5) -> count peaks at 4, 5th write forces drain of 0x0; then reads of all five return 1..5.
REQ-031 Read 0x300 after writes and drain, followed by three idle cycles -> rdata stays unchanged across idle cycles.
REQ-032 Push two writes, assert rst low for one cycle mid-stream -> rdata=0, wbuf_count=0 immediately; undrained words not in array.
REQ-033 Alternating read/write every cycle for 20 cycles -> no drains occur, count never exceeds 4 without forced drain, all reads match a reference model.

Source files
------------

// File: rtl/dsram_responder.sv
// dsram_responder: data-SRAM port model with a FIFO write buffer.
// Writes are posted into the buffer and retired to the single-ported array
// on idle cycles, or forcibly when the buffer is full and another write
// arrives. Reads return their data one cycle later with per-byte forwarding
// from the youngest matching buffered write, so program order is preserved.
module dsram_responder #(
    parameter int AW_WORDS = 12,
    parameter int WB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [2:0]  wbuf_count,
    output logic        wbuf_empty
);

    localparam int PW    = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int DEPTH = 1 << AW_WORDS;
    localparam logic [2:0] FULL_CNT = 3'(WB_DEPTH);

    // Overlay the enabled bytes of upd onto base.
    function automatic logic [31:0] byte_merge(input logic [31:0] base,
                                               input logic [31:0] upd,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = base;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? upd[8*b +: 8] : base[8*b +: 8];
        end
        return res;
    endfunction

    // Storage: array contents are never reset.
    logic [31:0]         mem_r     [DEPTH];
    logic [AW_WORDS-1:0] wb_idx_r  [WB_DEPTH];
    logic [3:0]          wb_wen_r  [WB_DEPTH];
    logic [31:0]         wb_data_r [WB_DEPTH];

    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [2:0]    count_r;
    logic [2:0]    count_nxt_s;
    logic          empty_r;
    logic [31:0]   rdata_r;

    logic [AW_WORDS-1:0] req_idx_s;
    logic                is_read_s;
    logic                is_write_s;
    logic                full_s;
    logic                push_s;
    logic                drain_s;
    logic [31:0]         fwd_data_s;
    logic                unused_s;

    assign req_idx_s  = data_sram_addr[AW_WORDS+1:2];
    assign is_read_s  = data_sram_en && (data_sram_wen == 4'b0000);
    assign is_write_s = data_sram_en && (data_sram_wen != 4'b0000);
    assign full_s     = (count_r == FULL_CNT);
    assign push_s     = is_write_s;
    // Idle cycles retire the head; a write into a full buffer retires it too,
    // so the array port is never shared with a read.
    assign drain_s    = (count_r != 3'd0) && (!data_sram_en || (is_write_s && full_s));

    // Byte offset and bits above the array depth are intentionally ignored.
    assign unused_s = ^{data_sram_addr[1:0], data_sram_addr[31:AW_WORDS+2]};

    // Read data: array word overlaid oldest-to-youngest with matching buffered bytes.
    always_comb begin
        fwd_data_s = mem_r[req_idx_s];
        for (int i = 0; i < WB_DEPTH; i++) begin
            logic [PW-1:0] slot;
            logic          hit;
            slot = head_r + PW'(i);
            hit  = (3'(i) < count_r) && (wb_idx_r[slot] == req_idx_s);
            fwd_data_s = byte_merge(fwd_data_s, wb_data_r[slot],
                                    hit ? wb_wen_r[slot] : 4'b0000);
        end
    end

    // Next occupancy: a simultaneous push and drain leaves it unchanged.
    always_comb begin
        case ({push_s, drain_s})
            2'b10:   count_nxt_s = count_r + 3'd1;
            2'b01:   count_nxt_s = count_r - 3'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Control state: pointers, occupancy, empty flag and the read data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 3'd0;
            empty_r <= 1'b1;
            rdata_r <= 32'h0000_0000;
        end else begin
            if (is_read_s) begin
                rdata_r <= fwd_data_s;
            end else begin
                rdata_r <= rdata_r;
            end
            if (push_s) begin
                tail_r <= tail_r + PW'(1'b1);
            end
            if (drain_s) begin
                head_r <= head_r + PW'(1'b1);
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == 3'd0);
        end
    end

    // Buffer payload: written at the tail on every accepted write.
    always_ff @(posedge clk) begin
        if (push_s) begin
            wb_idx_r[tail_r]  <= req_idx_s;
            wb_wen_r[tail_r]  <= data_sram_wen;
            wb_data_r[tail_r] <= data_sram_wdata;
        end
    end

    // Array write port: retire the head entry, enabled bytes only.
    always_ff @(posedge clk) begin
        if (drain_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_wen_r[head_r][b]) begin
                    mem_r[wb_idx_r[head_r]][8*b +: 8] <= wb_data_r[head_r][8*b +: 8];
                end
            end
        end
    end

    assign data_sram_rdata = rdata_r;
    assign wbuf_count      = count_r;
    assign wbuf_empty      = empty_r;

endmodule

// File: tb/tb_dsram_responder.sv
// Self-checking bench for dsram_responder: directed vector table, a reset
// sequence, then random traffic against a program-order reference model.
module tb_dsram_responder;

    localparam int WB_DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  count;
    logic        empty;

    int checks = 0;
    int errors = 0;

    dsram_responder #(.AW_WORDS(12), .WB_DEPTH(WB_DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .wbuf_count      (count),
        .wbuf_empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    typedef struct packed {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [2:0]  exp_count;
    } vec_t;

    typedef struct packed {
        logic [11:0] idx;
        logic [3:0]  wen;
        logic [31:0] data;
    } pend_t;

    // Reference model: drained array bytes plus the pending writes in order.
    logic [31:0] m_arr_d [int];
    logic [3:0]  m_arr_k [int];
    pend_t       m_q [$];
    logic [31:0] exp_rd;
    logic [3:0]  exp_k;

    function automatic logic [31:0] expand(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp, input logic [31:0] msk);
        checks++;
        if ((act & msk) !== (exp & msk)) begin
            errors++;
            $display("FAIL %s: got %h expected %h (mask %h) at %0t", nm, act, exp, msk, $time);
        end
    endtask

    task automatic drive(input logic e, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        en = e; wen = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    function automatic void m_read(input int idx, output logic [31:0] d, output logic [3:0] k);
        d = 32'h0; k = 4'h0;
        if (m_arr_k.exists(idx)) begin
            d = m_arr_d[idx];
            k = m_arr_k[idx];
        end
        foreach (m_q[j]) begin
            if (int'(m_q[j].idx) == idx) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_q[j].wen[b]) begin
                        d[8*b +: 8] = m_q[j].data[8*b +: 8];
                        k[b] = 1'b1;
                    end
                end
            end
        end
    endfunction

    function automatic void m_commit(input pend_t p);
        int idx;
        idx = int'(p.idx);
        if (!m_arr_k.exists(idx)) begin
            m_arr_d[idx] = 32'h0;
            m_arr_k[idx] = 4'h0;
        end
        for (int b = 0; b < 4; b++) begin
            if (p.wen[b]) begin
                m_arr_d[idx][8*b +: 8] = p.data[8*b +: 8];
                m_arr_k[idx][b] = 1'b1;
            end
        end
    endfunction

    // One cycle of traffic through both the DUT and the model, then compare.
    task automatic m_cycle(input logic e, input logic [3:0] w,
                           input logic [31:0] a, input logic [31:0] d);
        int    idx;
        pend_t p;
        idx = int'(a[13:2]);
        if (e && w == 4'h0) m_read(idx, exp_rd, exp_k);
        drive(e, w, a, d);
        if (e && w != 4'h0) begin
            if (m_q.size() == WB_DEPTH) begin
                p = m_q.pop_front();
                m_commit(p);
            end
            p.idx = a[13:2]; p.wen = w; p.data = d;
            m_q.push_back(p);
        end else if (!e && m_q.size() > 0) begin
            p = m_q.pop_front();
            m_commit(p);
        end
        if (exp_k != 4'h0) chk("model_rdata", rdata, exp_rd, expand(exp_k));
        chk("model_count", {29'h0, count}, m_q.size(), 32'hFFFF_FFFF);
        chk("model_empty", {31'h0, empty}, {31'h0, (m_q.size() == 0)}, 32'hFFFF_FFFF);
    endtask

    task automatic m_reset();
        rst = 1'b0;
        en = 1'b0; wen = 4'h0;
        #1;
        chk("rst_rdata", rdata, 32'h0, 32'hFFFF_FFFF);
        chk("rst_count", {29'h0, count}, 32'h0, 32'hFFFF_FFFF);
        chk("rst_empty", {31'h0, empty}, 32'h1, 32'hFFFF_FFFF);
        m_q.delete();
        exp_rd = 32'h0; exp_k = 4'hF;
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t vecs [$];

    initial begin
        logic [31:0] ra;
        int          sel;
        rst = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
        exp_rd = 32'h0; exp_k = 4'hF;

        // Table: en, wen, addr, wdata, expected rdata, expected count.
        vecs.push_back('{1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h00000000, 3'd1});
        vecs.push_back('{1'b1, 4'h0, 32'h100, 32'h0,        32'hDEADBEEF, 3'd1});
        vecs.push_back('{1'b0, 4'h0, 32'h0,   32'h0,        32'hDEADBEEF, 3'd0});
        vecs.push_back('{1'b1, 4'hF, 32'h200, 32'h11223344, 32'hDEADBEEF, 3'd1});
        vecs.push_back('{1'b1, 4'h1, 32'h200, 32'h000000AA, 32'hDEADBEEF, 3'd2});
        vecs.push_back('{1'b1, 4'h0, 32'h200, 32'h0,        32'h112233AA, 3'd2});
        vecs.push_back('{1'b0, 4'h0, 32'h0,   32'h0,        32'h112233AA, 3'd1});
        vecs.push_back('{1'b0, 4'h0, 32'h0,   32'h0,        32'h112233AA, 3'd0});
        vecs.push_back('{1'b1, 4'h0, 32'h200, 32'h0,        32'h112233AA, 3'd0});
        vecs.push_back('{1'b1, 4'hF, 32'h0,   32'h1,        32'h112233AA, 3'd1});
        vecs.push_back('{1'b1, 4'hF, 32'h4,   32'h2,        32'h112233AA, 3'd2});
        vecs.push_back('{1'b1, 4'hF, 32'h8,   32'h3,        32'h112233AA, 3'd3});
        vecs.push_back('{1'b1, 4'hF, 32'hC,   32'h4,        32'h112233AA, 3'd4});
        vecs.push_back('{1'b1, 4'hF, 32'h10,  32'h5,        32'h112233AA, 3'd4});
        vecs.push_back('{1'b1, 4'h0, 32'h0,   32'h0,        32'h00000001, 3'd4});
        vecs.push_back('{1'b1, 4'h0, 32'h4,   32'h0,        32'h00000002, 3'd4});
        vecs.push_back('{1'b1, 4'h0, 32'h8,   32'h0,        32'h00000003, 3'd4});
        vecs.push_back('{1'b1, 4'h0, 32'hC,   32'h0,        32'h00000004, 3'd4});
        vecs.push_back('{1'b1, 4'h0, 32'h10,  32'h0,        32'h00000005, 3'd4});
        vecs.push_back('{1'b0, 4'h0, 32'h0,   32'h0,        32'h00000005, 3'd3});
        vecs.push_back('{1'b0, 4'h0, 32'h0,   32'h0,        32'h00000005, 3'd2});
        vecs.push_back('{1'b0, 4'h0, 32'h0,   32'h0,        32'h00000005, 3'd1});
        vecs.push_back('{1'b0, 4'h0, 32'h0,   32'h0,        32'h00000005, 3'd0});
        vecs.push_back('{1'b1, 4'hF, 32'h300, 32'hCAFEF00D, 32'h00000005, 3'd1});
        vecs.push_back('{1'b0, 4'h0, 32'h0,   32'h0,        32'h00000005, 3'd0});
        vecs.push_back('{1'b1, 4'h0, 32'h300, 32'h0,        32'hCAFEF00D, 3'd0});
        vecs.push_back('{1'b0, 4'h0, 32'h0,   32'h0,        32'hCAFEF00D, 3'd0});
        vecs.push_back('{1'b0, 4'h0, 32'h0,   32'h0,        32'hCAFEF00D, 3'd0});
        vecs.push_back('{1'b0, 4'h0, 32'h0,   32'h0,        32'hCAFEF00D, 3'd0});
        vecs.push_back('{1'b0, 4'hF, 32'h300, 32'h0,        32'hCAFEF00D, 3'd0});
        vecs.push_back('{1'b1, 4'h0, 32'h302, 32'h0,        32'hCAFEF00D, 3'd0});
        vecs.push_back('{1'b1, 4'h0, 32'h10000300, 32'h0,   32'hCAFEF00D, 3'd0});

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 32'h0, 32'hFFFF_FFFF);
        chk("reset_count", {29'h0, count}, 32'h0, 32'hFFFF_FFFF);
        chk("reset_empty", {31'h0, empty}, 32'h1, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b1;

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata, 32'hFFFF_FFFF);
            chk($sformatf("vec%0d_count", i), {29'h0, count}, {29'h0, vecs[i].exp_count}, 32'hFFFF_FFFF);
            chk($sformatf("vec%0d_empty", i), {31'h0, empty},
                {31'h0, (vecs[i].exp_count == 3'd0)}, 32'hFFFF_FFFF);
        end

        // Reset mid-stream: drained words survive, buffered ones are lost.
        drive(1'b1, 4'hF, 32'h400, 32'h00000055);
        drive(1'b0, 4'h0, 32'h0,   32'h0);
        drive(1'b1, 4'hF, 32'h404, 32'h00000044);
        drive(1'b0, 4'h0, 32'h0,   32'h0);
        drive(1'b1, 4'hF, 32'h400, 32'h00000066);
        drive(1'b1, 4'hF, 32'h404, 32'h00000077);
        chk("mid_count", {29'h0, count}, 32'h2, 32'hFFFF_FFFF);
        drive(1'b1, 4'h0, 32'h400, 32'h0);
        chk("mid_fwd", rdata, 32'h00000066, 32'hFFFF_FFFF);
        en = 1'b0; wen = 4'h0;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_rdata", rdata, 32'h0, 32'hFFFF_FFFF);
        chk("midrst_count", {29'h0, count}, 32'h0, 32'hFFFF_FFFF);
        chk("midrst_empty", {31'h0, empty}, 32'h1, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 4'h0, 32'h400, 32'h0);
        chk("post_rst_400", rdata, 32'h00000055, 32'hFFFF_FFFF);
        drive(1'b1, 4'h0, 32'h404, 32'h0);
        chk("post_rst_404", rdata, 32'h00000044, 32'hFFFF_FFFF);
        chk("post_rst_count", {29'h0, count}, 32'h0, 32'hFFFF_FFFF);

        // Model-checked traffic over word indices 0x500..0x507: seed, then drain.
        exp_rd = rdata_known_value();
        exp_k = 4'hF;
        for (int i = 0; i < 8; i++) m_cycle(1'b1, 4'hF, (32'h500 + i) << 2, $urandom());
        for (int i = 0; i < 6; i++) m_cycle(1'b0, 4'h0, 32'h0, 32'h0);

        // Alternating write/read: no idle cycles, so only forced drains.
        for (int i = 0; i < 20; i++) begin
            ra = (32'h500 + $urandom_range(0, 7)) << 2;
            if (i % 2 == 0) m_cycle(1'b1, 4'($urandom_range(1, 15)), ra, $urandom());
            else            m_cycle(1'b1, 4'h0, ra, 32'h0);
        end

        // Random mix including ignored wen, odd address bits and rare resets.
        for (int i = 0; i < 600; i++) begin
            ra  = ((32'h500 + $urandom_range(0, 7)) << 2) | ($urandom() & 32'hFFFF_C003);
            sel = $urandom_range(0, 9);
            if (sel < 4)       m_cycle(1'b1, 4'($urandom_range(1, 15)), ra, $urandom());
            else if (sel < 7)  m_cycle(1'b1, 4'h0, ra, 32'h0);
            else if (sel < 9)  m_cycle(1'b0, 4'($urandom_range(0, 15)), ra, $urandom());
            else if ($urandom_range(0, 15) == 0) m_reset();
            else               m_cycle(1'b0, 4'h0, 32'h0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Last value the directed reset sequence left on the read port.
    function automatic logic [31:0] rdata_known_value();
        return 32'h00000044;
    endfunction

endmodule
